// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - instruction fetch FSM with held-instruction register and field decode
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] pc_out,
    output logic [31:0] pc_plus4,
    output logic [5:0]  opcode,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [4:0]  rd,
    output logic [4:0]  shamt,
    output logic [5:0]  funct,
    output logic [15:0] imm16
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_VALID = 2'd2
    } state_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_instr;
    logic [31:0] r_pc_out;

    state_t      w_state_nxt;
    logic [31:0] w_pc_nxt;
    logic [31:0] w_instr_nxt;
    logic [31:0] w_pc_out_nxt;
    logic [31:0] w_target_aligned;
    logic        w_unused_target_lsbs;

    // Branch targets are word addresses; the two low bits carry no information.
    assign w_target_aligned     = {branch_target[31:2], 2'b00};
    assign w_unused_target_lsbs = &{1'b0, branch_target[1:0]};

    // State, fetch pointer and held instruction registers; reset wins over every input.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_pc     <= RESET_PC;
            r_instr  <= 32'h0000_0000;
            r_pc_out <= 32'h0000_0000;
        end else begin
            r_state  <= w_state_nxt;
            r_pc     <= w_pc_nxt;
            r_instr  <= w_instr_nxt;
            r_pc_out <= w_pc_out_nxt;
        end
    end

    // Next-state and Moore outputs; a branch always beats both returning data and stall.
    always_comb begin
        w_state_nxt  = r_state;
        w_pc_nxt     = r_pc;
        w_instr_nxt  = r_instr;
        w_pc_out_nxt = r_pc_out;
        mem_req      = 1'b0;
        instr_valid  = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_state_nxt = S_FETCH;
            end
            S_FETCH: begin
                mem_req = 1'b1;
                if (branch_taken) begin
                    w_pc_nxt = w_target_aligned;
                end else if (mem_ready) begin
                    w_instr_nxt  = mem_rdata;
                    w_pc_out_nxt = r_pc;
                    w_pc_nxt     = r_pc + 32'd4;
                    w_state_nxt  = S_VALID;
                end
            end
            S_VALID: begin
                instr_valid = 1'b1;
                if (branch_taken) begin
                    w_pc_nxt    = w_target_aligned;
                    w_state_nxt = S_FETCH;
                end else if (!stall) begin
                    w_state_nxt = S_FETCH;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign mem_addr = r_pc;
    assign instr    = r_instr;
    assign pc_out   = r_pc_out;
    assign pc_plus4 = r_pc_out + 32'd4;

    assign opcode = r_instr[31:26];
    assign rs     = r_instr[25:21];
    assign rt     = r_instr[20:16];
    assign rd     = r_instr[15:11];
    assign shamt  = r_instr[10:6];
    assign funct  = r_instr[5:0];
    assign imm16  = r_instr[15:0];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - randomized scoreboard bench for instr_fetch_unit
module tb_instr_fetch_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // main instance, RESET_PC = 0
    logic        rst_n, mem_req, mem_ready, stall, branch_taken, instr_valid;
    logic [31:0] mem_addr, mem_rdata, branch_target, instr, pc_out, pc_plus4;
    logic [5:0]  opcode, funct;
    logic [4:0]  rs, rt, rd, shamt;
    logic [15:0] imm16;

    // wrap instance, RESET_PC at the top of the address space
    logic        w_rst_n, w_mem_req, w_mem_ready, w_stall, w_branch_taken, w_instr_valid;
    logic [31:0] w_mem_addr, w_mem_rdata, w_branch_target, w_instr, w_pc_out, w_pc_plus4;
    logic [5:0]  w_opcode, w_funct;
    logic [4:0]  w_rs, w_rt, w_rd, w_shamt;
    logic [15:0] w_imm16;

    instr_fetch_unit #(.RESET_PC(32'h0000_0000)) u_dut (
        .clk(clk), .rst_n(rst_n), .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata), .stall(stall),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .instr_valid(instr_valid), .instr(instr), .pc_out(pc_out), .pc_plus4(pc_plus4),
        .opcode(opcode), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .funct(funct),
        .imm16(imm16)
    );

    instr_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
        .clk(clk), .rst_n(w_rst_n), .mem_req(w_mem_req), .mem_addr(w_mem_addr),
        .mem_ready(w_mem_ready), .mem_rdata(w_mem_rdata), .stall(w_stall),
        .branch_taken(w_branch_taken), .branch_target(w_branch_target),
        .instr_valid(w_instr_valid), .instr(w_instr), .pc_out(w_pc_out), .pc_plus4(w_pc_plus4),
        .opcode(w_opcode), .rs(w_rs), .rt(w_rt), .rd(w_rd), .shamt(w_shamt), .funct(w_funct),
        .imm16(w_imm16)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [31:0] pc;
        logic [31:0] word;
    } item_t;

    item_t sb_q[$];

    // reference model: what the fetcher is doing and where it fetches from
    typedef enum int {M_IDLE, M_FETCHING, M_HOLDING} mphase_t;
    mphase_t     m_phase;
    logic [31:0] m_pc;
    bit          m_cleared;
    bit          mon_en    = 1'b0;
    bit          wrap_done = 1'b0;

    // monitor: each newly presented instruction is checked against the scoreboard,
    // and a held instruction must not change
    item_t cur;
    bit    prev_v   = 1'b0;
    bit    have_cur = 1'b0;
    always @(negedge clk) begin
        if (mon_en) begin
            if (instr_valid === 1'b1 && !prev_v) begin
                if (sb_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL sb_empty: instr_valid=1 with no expected instruction (t=%0t)", $time);
                end else begin
                    cur = sb_q.pop_front();
                    have_cur = 1'b1;
                    chk("instr",    instr,    cur.word);
                    chk("pc_out",   pc_out,   cur.pc);
                    chk("pc_plus4", pc_plus4, cur.pc + 32'd4);
                    chk("opcode",   {26'd0, opcode}, cur.word >> 26);
                    chk("rs",       {27'd0, rs},     (cur.word >> 21) & 32'h1F);
                    chk("rt",       {27'd0, rt},     (cur.word >> 16) & 32'h1F);
                    chk("rd",       {27'd0, rd},     (cur.word >> 11) & 32'h1F);
                    chk("shamt",    {27'd0, shamt},  (cur.word >> 6) & 32'h1F);
                    chk("funct",    {26'd0, funct},  cur.word & 32'h3F);
                    chk("imm16",    {16'd0, imm16},  cur.word & 32'hFFFF);
                end
            end else if (instr_valid === 1'b1 && have_cur) begin
                chk("hold_instr",  instr,  cur.word);
                chk("hold_pc_out", pc_out, cur.pc);
            end
            prev_v = (instr_valid === 1'b1);
        end
    end

    // main driver: random stimulus, control-output checks, model update
    initial begin
        rst_n         = 1'b0;
        mem_ready     = 1'b0;
        mem_rdata     = 32'h0;
        stall         = 1'b0;
        branch_taken  = 1'b0;
        branch_target = 32'h0;
        m_phase       = M_IDLE;
        m_pc          = 32'h0000_0000;
        m_cleared     = 1'b1;
        @(posedge clk);
        mon_en = 1'b1;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            chk("mem_req",     {31'd0, mem_req},     {31'd0, m_phase == M_FETCHING});
            chk("instr_valid", {31'd0, instr_valid}, {31'd0, m_phase == M_HOLDING});
            if (m_phase != M_HOLDING)
                chk("mem_addr", mem_addr, m_pc);
            if (m_cleared) begin
                chk("rst_instr",    instr,    32'h0);
                chk("rst_pc_out",   pc_out,   32'h0);
                chk("rst_pc_plus4", pc_plus4, 32'h4);
                chk("rst_fields",   {opcode, rs, rt, rd, shamt, funct}, 32'h0);
            end

            rst_n         = (cyc < 2) ? 1'b0 : ($urandom_range(0, 299) != 0);
            mem_ready     = ($urandom_range(0, 2) != 0);
            mem_rdata     = $urandom;
            stall         = ($urandom_range(0, 3) != 0);
            branch_taken  = ($urandom_range(0, 9) == 0);
            branch_target = $urandom;

            if (!rst_n) begin
                m_phase   = M_IDLE;
                m_pc      = 32'h0000_0000;
                m_cleared = 1'b1;
            end else begin
                case (m_phase)
                    M_IDLE: m_phase = M_FETCHING;
                    M_FETCHING: begin
                        if (branch_taken) begin
                            m_pc = branch_target & ~32'h3;
                        end else if (mem_ready) begin
                            sb_q.push_back('{pc: m_pc, word: mem_rdata});
                            m_pc      = m_pc + 32'd4;
                            m_phase   = M_HOLDING;
                            m_cleared = 1'b0;
                        end
                    end
                    default: begin
                        if (branch_taken) begin
                            m_pc    = branch_target & ~32'h3;
                            m_phase = M_FETCHING;
                        end else if (!stall) begin
                            m_phase = M_FETCHING;
                        end
                    end
                endcase
            end
        end
        for (int k = 0; k < 100 && !wrap_done; k++) @(negedge clk);
        if (!wrap_done) begin
            n_vec++;
            n_err++;
            $display("FAIL wrap_timeout: wrap sequence done=0, expected 1");
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // directed sequence on the wrap instance: fetch at 0xFFFFFFFC wraps to 0
    initial begin
        w_rst_n         = 1'b0;
        w_mem_ready     = 1'b1;
        w_mem_rdata     = 32'h2008_FFFF;
        w_stall         = 1'b0;
        w_branch_taken  = 1'b0;
        w_branch_target = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("wrap_rst_addr", w_mem_addr, 32'hFFFF_FFFC);
        chk("wrap_rst_req",  {31'd0, w_mem_req}, 32'd0);
        w_rst_n = 1'b1;
        @(negedge clk);
        chk("wrap_fetch_req",  {31'd0, w_mem_req}, 32'd1);
        chk("wrap_fetch_addr", w_mem_addr, 32'hFFFF_FFFC);
        @(negedge clk);
        chk("wrap_valid",    {31'd0, w_instr_valid}, 32'd1);
        chk("wrap_pc_out",   w_pc_out,   32'hFFFF_FFFC);
        chk("wrap_pc_plus4", w_pc_plus4, 32'h0000_0000);
        chk("wrap_opcode",   {26'd0, w_opcode}, 32'h08);
        chk("wrap_rt",       {27'd0, w_rt},     32'h08);
        chk("wrap_imm16",    {16'd0, w_imm16},  32'hFFFF);
        w_mem_ready = 1'b0;
        @(negedge clk);
        chk("wrap_next_req",  {31'd0, w_mem_req}, 32'd1);
        chk("wrap_next_addr", w_mem_addr, 32'h0000_0000);
        wrap_done = 1'b1;
    end

endmodule

// File: doc/instr_fetch_unit.md
INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h00000000, address of the first fetch after reset; bits [1:0] shall be zero.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 mem_req  output  1  fetch request to instruction memory.
REQ-005 mem_addr  output  32  word-aligned fetch address; valid while mem_req=1.
REQ-006 mem_ready  input  1  memory has mem_rdata valid for current mem_addr.
REQ-007 mem_rdata  input  32  instruction word from memory.
REQ-008 stall  input  1  decode cannot accept the held instruction this cycle.
REQ-009 branch_taken  input  1  redirect fetch; flushes any held or in-flight instruction.
REQ-010 branch_target  input  32  redirect address; bits [1:0] ignored, forced to 00.
REQ-011 instr_valid  output  1  instr and decoded fields are valid.
REQ-012 instr  output  32  instruction register contents.
REQ-013 pc_out / pc_plus4  output  32 each  address of held instruction / that address + 4.
REQ-014 opcode[5:0], rs[4:0], rt[4:0], rd[4:0], shamt[4:0], funct[5:0]  outputs  instruction fields.
REQ-015 imm16  output  16  instr[15:0], feeds the 16-to-32 sign-extension stage directly.

Function
REQ-016 FSM states: IDLE, FETCH, VALID; state, pc, instr and pc_out are registers.
REQ-017 IDLE: mem_req=0, instr_valid=0; next state FETCH unconditionally.
REQ-018 FETCH: mem_req=1, mem_addr=pc, instr_valid=0.
REQ-019 FETCH, branch_taken=1: pc <= {branch_target[31:2],2'b00}, stay FETCH, mem_rdata discarded even if mem_ready=1 (branch has priority).
REQ-020 FETCH, branch_taken=0, mem_ready=1: instr <= mem_rdata, pc_out <= pc, pc <= pc+4, next VALID.
REQ-021 FETCH, mem_ready=0: hold pc and mem_addr stable, stay FETCH; no timeout.
REQ-022 VALID: mem_req=0, instr_valid=1; instr, fields, pc_out stable while stall=1.
REQ-023 VALID, branch_taken=1: pc <= aligned branch_target, next FETCH, instr_valid drops next cycle regardless of stall.
REQ-024 VALID, branch_taken=0, stall=0: instruction consumed this cycle, next FETCH.
REQ-025 mem_ready shall be ignored outside FETCH.
REQ-026 Field decode combinational from instr: opcode=[31:26], rs=[25:21], rt=[20:16], rd=[15:11], shamt=[10:6], funct=[5:0], imm16=[15:0].
REQ-027 pc_plus4 = pc_out + 4, modulo 2^32; pc increment likewise wraps 32'hFFFFFFFC -> 32'h00000000.
REQ-028 Peak throughput one instruction per two cycles (FETCH + VALID) with zero-wait memory.
REQ-029 An address change while mem_req=1 (branch abort) shall be treated by memory as a new request.

Reset
REQ-030 On a rising edge with rst_n=0: state <= IDLE, pc <= RESET_PC, instr <= 0, pc_out <= 0.
REQ-031 Resulting outputs: mem_req=0, instr_valid=0, instr=0, all fields 0, pc_out=0, pc_plus4=4, mem_addr=RESET_PC.
REQ-032 Reset overrides branch_taken, stall and mem_ready in any state, including mid-fetch; in-flight data discarded.

Verification
REQ-033 rst_n=0 for 3 cycles, then 1 -> outputs per REQ-031 during reset; one IDLE cycle; then mem_req=1, mem_addr=0x00000000.
REQ-034 FETCH, mem_ready=1, mem_rdata=0x2008FFFF, stall=0 -> next cycle instr_valid=1, opcode=0x08, rs=0, rt=8, imm16=0xFFFF, pc_out=0, pc_plus4=4; following cycle mem_req=1, mem_addr=0x00000004.
REQ-035 mem_ready low 3 cycles then high -> mem_req=1 and mem_addr constant for 4 cycles; instr_valid=1 only the cycle after mem_ready.
REQ-036 VALID with stall=1 for 5 cycles -> instr_valid=1, instr and pc_out unchanged, mem_req=0 throughout; fetch resumes cycle after stall=0.
REQ-037 FETCH with branch_taken=1, mem_ready=1, branch_target=0x00000103 -> rdata dropped, instr_valid stays 0, next mem_addr=0x00000100; repeat in VALID with stall=1 -> instr_valid=0 next cycle.
REQ-038 RESET_PC=0xFFFFFFFC, zero-wait fetch -> pc_out=0xFFFFFFFC, pc_plus4=0x00000000, next mem_addr=0x00000000.
